// File: rtl/riscv_clint_timer.sv
// CLINT-lite: memory-mapped 64-bit mtime/mtimecmp timer and msip software interrupt
// on the core's data bus, answering each hit with a single-cycle acknowledge.
module riscv_clint_timer #(
   parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
   parameter int unsigned PRESCALE  = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wr_data,
   input  logic [3:0]  data_mask,
   input  logic        data_wr_en,
   input  logic        data_req,
   output logic        data_ack,
   output logic [31:0] data_rd_data,
   output logic        software_interrupt,
   output logic        timer_interrupt
);

   typedef enum logic {
      IDLE,
      RESP
   } state_t;

   localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

   state_t      state;
   logic [15:0] prescaler;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;

   logic        tick;
   logic        hit;
   logic        wr_hit;
   logic [2:0]  reg_sel;
   logic [63:0] mtime_inc;
   logic [63:0] mtime_next;
   logic [63:0] mtimecmp_next;
   logic [31:0] rd_mux;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^data_addr[1:0];

   assign tick      = (prescaler == PRESCALE_MAX);
   assign reg_sel   = data_addr[4:2];
   assign hit       = data_req && (state == IDLE) && (data_addr[31:5] == BASE_ADDR[31:5]);
   assign wr_hit    = hit && data_wr_en;
   assign mtime_inc = tick ? (mtime + 64'd1) : mtime;

   assign software_interrupt = msip;

   function automatic logic [31:0] merge_bytes(
      input logic [31:0] old_val,
      input logic [31:0] new_val,
      input logic [3:0]  mask
   );
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

   // Written bytes override the tick; everything else of mtime still advances.
   always_comb begin
      mtime_next    = mtime_inc;
      mtimecmp_next = mtimecmp;
      if (wr_hit) begin
         case (reg_sel)
            3'd2: mtimecmp_next[31:0]  = merge_bytes(mtimecmp[31:0], data_wr_data, data_mask);
            3'd3: mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], data_wr_data, data_mask);
            3'd4: mtime_next[31:0]     = merge_bytes(mtime_inc[31:0], data_wr_data, data_mask);
            3'd5: mtime_next[63:32]    = merge_bytes(mtime_inc[63:32], data_wr_data, data_mask);
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         3'd0: rd_mux = {31'd0, msip};
         3'd2: rd_mux = mtimecmp[31:0];
         3'd3: rd_mux = mtimecmp[63:32];
         3'd4: rd_mux = mtime[31:0];
         3'd5: rd_mux = mtime[63:32];
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler       <= '0;
         mtime           <= '0;
         mtimecmp        <= '1;
         msip            <= 1'b0;
         timer_interrupt <= 1'b0;
      end else begin
         prescaler       <= tick ? 16'd0 : (prescaler + 16'd1);
         mtime           <= mtime_next;
         mtimecmp        <= mtimecmp_next;
         timer_interrupt <= (mtime >= mtimecmp);
         if (wr_hit && (reg_sel == 3'd0) && data_mask[0]) begin
            msip <= data_wr_data[0];
         end
      end
   end

   // Bus handshake: RESP never samples data_req, so a held request is re-taken a cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         data_ack     <= 1'b0;
         data_rd_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  state        <= RESP;
                  data_ack     <= 1'b1;
                  data_rd_data <= data_wr_en ? 32'd0 : rd_mux;
               end
            end
            RESP: begin
               state        <= IDLE;
               data_ack     <= 1'b0;
               data_rd_data <= '0;
            end
            default: begin
               state        <= IDLE;
               data_ack     <= 1'b0;
               data_rd_data <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_clint_timer.sv
// Bench for riscv_clint_timer: one instance with PRESCALE=4 and one with PRESCALE=1,
// a read-data scoreboard popped on data_ack, a vector table and hand-written timing sequences.
module tb_riscv_clint_timer;

   localparam logic [31:0] BASE = 32'hF000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [3:0]  mask;
   logic        wr_en;
   logic        req4, req1;
   logic        ack4, ack1;
   logic [31:0] rd4, rd1;
   logic        si4, si1;
   logic        ti4, ti1;

   always #5 clk = ~clk;

   riscv_clint_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .data_addr(addr), .data_wr_data(wr_data), .data_mask(mask),
      .data_wr_en(wr_en), .data_req(req4), .data_ack(ack4), .data_rd_data(rd4),
      .software_interrupt(si4), .timer_interrupt(ti4)
   );

   riscv_clint_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .data_addr(addr), .data_wr_data(wr_data), .data_mask(mask),
      .data_wr_en(wr_en), .data_req(req1), .data_ack(ack1), .data_rd_data(rd1),
      .software_interrupt(si1), .timer_interrupt(ti1)
   );

   typedef struct {
      logic [31:0] data;
      logic [31:0] tol;
      bit          chk;
   } sb_t;

   typedef struct {
      bit          wr;
      logic [7:0]  off;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] exp;
      bit          exp_si;
   } vec_t;

   sb_t  sb4[$];
   sb_t  sb1[$];
   sb_t  mon_e4, mon_e1;
   vec_t vecs[19];
   int   checks = 0;
   int   errors = 0;
   bit   ack_ti, ack_si;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkRange(input string name, input logic [31:0] act, input logic [31:0] exp,
                             input logic [31:0] tol);
      logic [31:0] diff;
      diff = (act > exp) ? (act - exp) : (exp - act);
      checks++;
      if ($isunknown(act) || diff > tol) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (+/-%0d)", name, act, exp, tol);
      end
   endtask

   // Scoreboard: every acknowledge consumes the oldest expected entry.
   always @(negedge clk) begin
      if (ack4) begin
         if (sb4.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack4: got ack with rd_data %h, required no ack", rd4);
         end else begin
            mon_e4 = sb4.pop_front();
            if (mon_e4.chk) checkRange("rd_data4", rd4, mon_e4.data, mon_e4.tol);
         end
      end
      if (ack1) begin
         if (sb1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack1: got ack with rd_data %h, required no ack", rd1);
         end else begin
            mon_e1 = sb1.pop_front();
            if (mon_e1.chk) checkRange("rd_data1", rd1, mon_e1.data, mon_e1.tol);
         end
      end
   end

   // Called at a negedge with the slave idle; returns at a negedge with the slave idle again.
   task automatic applyStimulus(input bit sel, input bit wr, input logic [7:0] off,
                                input logic [31:0] wdata, input logic [3:0] m,
                                input logic [31:0] exp, input logic [31:0] tol, input bit chk,
                                output bit ti, output bit si);
      int n;
      bit got;
      addr    = BASE + {24'd0, off};
      wr_data = wdata;
      mask    = m;
      wr_en   = wr;
      if (sel) begin
         sb1.push_back('{exp, tol, chk});
         req1 = 1'b1;
      end else begin
         sb4.push_back('{exp, tol, chk});
         req4 = 1'b1;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         got = sel ? ack1 : ack4;
      end while (!got && n < 8);
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL ack_timeout: got no ack in %0d cycles, required ack after 1", n);
         if (sel) sb1.delete(); else sb4.delete();
      end else begin
         checkOutput("ack_latency", n, 1);
      end
      ti   = sel ? ti1 : ti4;
      si   = sel ? si1 : si4;
      req1 = 1'b0;
      req4 = 1'b0;
      @(negedge clk);
      checkOutput("ack_one_cycle", sel ? ack1 : ack4, 0);
   endtask

   task automatic write_reg(input bit sel, input logic [7:0] off, input logic [31:0] d,
                            input logic [3:0] m);
      applyStimulus(sel, 1'b1, off, d, m, 32'd0, 32'd0, 1'b0, ack_ti, ack_si);
   endtask

   task automatic read_reg(input bit sel, input logic [7:0] off, input logic [31:0] exp,
                           input logic [31:0] tol);
      applyStimulus(sel, 1'b0, off, 32'd0, 4'h0, exp, tol, 1'b1, ack_ti, ack_si);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit any_out;
      int miss_acks;

      vecs[0]  = '{1'b1, 8'h00, 32'h0000_0001, 4'hF, 32'h0, 1'b1};
      vecs[1]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h1, 1'b1};
      vecs[2]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
      vecs[3]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h1, 1'b1};
      vecs[4]  = '{1'b1, 8'h00, 32'h0,         4'hE, 32'h0, 1'b1};
      vecs[5]  = '{1'b1, 8'h00, 32'h0,         4'hF, 32'h0, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0, 1'b0};
      vecs[7]  = '{1'b1, 8'h08, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
      vecs[8]  = '{1'b0, 8'h08, 32'h0,         4'h0, 32'hFFBB_FFDD, 1'b0};
      vecs[9]  = '{1'b1, 8'h0C, 32'h1234_5678, 4'h0, 32'h0, 1'b0};
      vecs[10] = '{1'b0, 8'h0C, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0};
      vecs[11] = '{1'b1, 8'h0C, 32'h0000_0055, 4'h1, 32'h0, 1'b0};
      vecs[12] = '{1'b0, 8'h0F, 32'h0,         4'h0, 32'hFFFF_FF55, 1'b0};
      vecs[13] = '{1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
      vecs[14] = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0, 1'b0};
      vecs[15] = '{1'b1, 8'h18, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
      vecs[16] = '{1'b0, 8'h18, 32'h0,         4'h0, 32'h0, 1'b0};
      vecs[17] = '{1'b0, 8'h1C, 32'h0,         4'h0, 32'h0, 1'b0};
      vecs[18] = '{1'b0, 8'h09, 32'h0,         4'h0, 32'hFFBB_FFDD, 1'b0};

      rst = 1'b1; req4 = 1'b0; req1 = 1'b0;
      addr = '0; wr_data = '0; mask = '0; wr_en = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs4", {ack4, si4, ti4, rd4}, 0);
      checkOutput("reset_outputs1", {ack1, si1, ti1, rd1}, 0);

      rst = 1'b0;
      any_out = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ack4 || si4 || ti4 || rd4 != 0 || ack1 || si1 || ti1 || rd1 != 0) any_out = 1'b1;
      end
      checkOutput("idle_outputs", any_out, 0);
      read_reg(0, 8'h10, 32'd10, 32'd1);
      read_reg(0, 8'h14, 32'd0, 32'd0);

      for (int i = 0; i < 19; i++) begin
         applyStimulus(0, vecs[i].wr, vecs[i].off, vecs[i].wdata, vecs[i].mask,
                       vecs[i].exp, 32'd0, !vecs[i].wr, ack_ti, ack_si);
         checkOutput($sformatf("vec%0d_si", i), ack_si, vecs[i].exp_si);
         checkOutput($sformatf("vec%0d_ti", i), ack_ti, 0);
      end

      addr = BASE + 32'h48; wr_data = 32'h0; mask = 4'hF; wr_en = 1'b1; req4 = 1'b1;
      miss_acks = 0;
      repeat (20) begin
         @(negedge clk);
         if (ack4) miss_acks++;
      end
      req4 = 1'b0;
      checkOutput("miss_no_ack", miss_acks, 0);
      read_reg(0, 8'h08, 32'hFFBB_FFDD, 32'd0);

      write_reg(1, 8'h14, 32'h0, 4'hF);
      write_reg(1, 8'h10, 32'hFFFF_FFFF, 4'hF);
      read_reg(1, 8'h10, 32'h0, 32'd0);
      read_reg(1, 8'h14, 32'h1, 32'd0);
      write_reg(1, 8'h14, 32'hFFFF_FFFF, 4'hF);
      write_reg(1, 8'h10, 32'hFFFF_FFFF, 4'hF);
      read_reg(1, 8'h10, 32'h0, 32'd0);
      read_reg(1, 8'h14, 32'h0, 32'd0);

      write_reg(1, 8'h10, 32'h0000_10FE, 4'hF);
      write_reg(1, 8'h10, 32'h0, 4'h1);
      read_reg(1, 8'h10, 32'h0000_1101, 32'd0);

      write_reg(1, 8'h10, 32'h0, 4'hF);
      write_reg(1, 8'h08, 32'd100, 4'hF);
      write_reg(1, 8'h0C, 32'h0, 4'hF);
      write_reg(1, 8'h10, 32'd98, 4'hF);
      checkOutput("ti_mtime99", ti1, 0);
      @(negedge clk);
      checkOutput("ti_mtime100", ti1, 0);
      @(negedge clk);
      checkOutput("ti_rise", ti1, 1);
      write_reg(1, 8'h0C, 32'h1, 4'hF);
      checkOutput("ti_held_at_commit", ack_ti, 1);
      checkOutput("ti_cleared", ti1, 0);

      addr = BASE + 32'h08; wr_en = 1'b0; mask = 4'h0; req4 = 1'b1;
      for (int k = 0; k < 3; k++) sb4.push_back('{32'hFFBB_FFDD, 32'd0, 1'b1});
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checkOutput($sformatf("b2b_ack%0d", k), ack4, (k % 2 == 1) ? 1 : 0);
         if (k % 2 == 0) checkOutput($sformatf("b2b_rd_zero%0d", k), rd4, 0);
      end
      req4 = 1'b0;
      @(negedge clk);
      checkOutput("b2b_end", {ack4, rd4}, 0);

      write_reg(0, 8'h00, 32'h1, 4'hF);
      addr = BASE + 32'h08; wr_en = 1'b0; req4 = 1'b1;
      sb4.push_back('{32'hFFBB_FFDD, 32'd0, 1'b1});
      @(negedge clk);
      checkOutput("resp_before_reset", ack4, 1);
      rst = 1'b1; req4 = 1'b0;
      @(negedge clk);
      checkOutput("reset_in_resp", {ack4, si4, ti4, rd4}, 0);
      rst = 1'b0;
      read_reg(0, 8'h10, 32'h0, 32'd0);
      read_reg(0, 8'h08, 32'hFFFF_FFFF, 32'd0);
      read_reg(0, 8'h00, 32'h0, 32'd0);
      read_reg(1, 8'h0C, 32'hFFFF_FFFF, 32'd0);

      addr = BASE; wr_data = 32'h1; mask = 4'hF; wr_en = 1'b1; req4 = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; req4 = 1'b0;
      checkOutput("reset_drops_write", {ack4, si4}, 0);
      @(negedge clk);
      checkOutput("reset_no_late_ack", {ack4, si4}, 0);

      checkOutput("scoreboard_empty", sb4.size() + sb1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_clint_timer.md
Name: riscv_clint_timer

Overview:
- Memory-mapped machine timer and software-interrupt unit (CLINT-lite) on the core's data memory bus.
- Decodes its own address window and answers the data req/ack handshake.
- Holds a 64-bit mtime counter, a 64-bit mtimecmp register and an msip bit.
- Drives the core's timer_interrupt and software_interrupt inputs.

Parameters:
BASE_ADDR, 32'hF000_0000, base of the 32-byte register window (must be 32-byte aligned)
PRESCALE, 50, clk cycles per mtime increment (50 MHz clock gives a 1 MHz tick); legal range 1..65535

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
data_addr  input  32  byte address from core
data_wr_data  input  32  write data
data_mask  input  4  byte enables; bit n covers data_wr_data[8n+7:8n]
data_wr_en  input  1  1 = write, 0 = read
data_req  input  1  request valid; held by core until data_ack
data_ack  output  1  one-cycle acknowledge
data_rd_data  output  32  read data, valid while data_ack=1, else 0
software_interrupt  output  1  msip bit
timer_interrupt  output  1  registered (mtime >= mtimecmp)

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: data_ack=0, data_rd_data=0, software_interrupt=0, timer_interrupt=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, FSM=IDLE.
- Reset mid-transaction: abandons the transaction; no ack is issued; register writes not yet committed are lost.
- Address decode: hit = data_req && (data_addr[31:5] == BASE_ADDR[31:5]). Misses are ignored entirely: no ack, no state change. Another slave owns them.
- Register map (offset = data_addr[4:2]*4):
  - 0x00 msip: bit0 readable and writable, other bits read 0.
  - 0x08 mtimecmp[31:0].
  - 0x0C mtimecmp[63:32].
  - 0x10 mtime[31:0].
  - 0x14 mtime[63:32].
  - 0x04, 0x18, 0x1C: read 0; writes are ignored but still acked.
- Address bits [1:0] are ignored.
- FSM, two states:
  - IDLE: on a hit, perform the access at the clock edge (write commits, or read data is captured into data_rd_data), set data_ack=1, go to RESP.
  - RESP: data_ack=1 for exactly this cycle; data_rd_data holds the captured value. data_req is not sampled. Next state is IDLE with data_ack=0 and data_rd_data=0.
- Latency: ack arrives 1 cycle after req is first seen. Maximum throughput is one access per 2 cycles.
- Requester obligation: data_req may stay high across RESP for a back-to-back access, which IDLE samples on the following cycle.
- Writes: byte-masked. Only bytes with data_mask[n]=1 are updated; mask 0000 changes nothing but is still acked.
- Read capture: read data is a snapshot at the capture edge. Reading mtime[31:0] then mtime[63:32] is not atomic; software handles the carry.
- Prescaler:
  - Counts 0..PRESCALE-1 every cycle and wraps to 0.
  - tick = (prescaler == PRESCALE-1). When PRESCALE=1, tick is 1 every cycle.
  - On tick, mtime <= mtime+1 as a full 64-bit add. The carry propagates from the low word to the high word; 2^64-1 wraps to 0.
  - A write to mtime does not reset the prescaler.
- Simultaneous write and tick on mtime: the write has priority for the written word. Bytes not written in that word, and the other word, take the incremented value (mtime+1) for that cycle.
- timer_interrupt: registered each cycle from (mtime >= mtimecmp) as an unsigned 64-bit compare, using the pre-edge register values. It follows a changed mtime or mtimecmp one cycle later.
- Clearing the timer interrupt: writing a larger mtimecmp deasserts timer_interrupt one cycle after the write commits. It stays asserted for as long as the compare holds.
- software_interrupt: equals the msip register directly. It changes at the write-commit edge.

Test Plan:
1. Reset with PRESCALE=4, then run 40 cycles with no requests -> mtime reads 10 (±1 depending on capture edge); all outputs 0 during and after reset; timer_interrupt stays 0 because mtimecmp is all ones.
2. Write 0x1 to BASE+0x00, mask 1111 -> data_ack high on the cycle after req only; software_interrupt=1 from the commit edge. Then write 0x0 -> software_interrupt=0.
3. Write mtime lo=0xFFFF_FFFF, hi=0, PRESCALE=1 -> one cycle later mtime hi reads 1 and lo reads 0 (carry). Also: mtime=64'hFFFF_FFFF_FFFF_FFFF -> wraps to 0.
4. mtimecmp=100, mtime=98, PRESCALE=1 -> timer_interrupt rises 1 cycle after mtime reaches 100. Writing mtimecmp hi=1 drops it one cycle after that write commits.
5. Byte masking: write 0xAABBCCDD with mask 0101 to mtimecmp lo (reset value 0xFFFF_FFFF) -> reads back 0xFFBBFFDD. A request to BASE+0x40 (outside the window) -> no ack for 20 cycles and no register change.
6. Back-to-back reads with data_req held continuously -> acks on alternate cycles, with data_rd_data nonzero only in ack cycles. Asserting rst during RESP -> data_ack=0 on the next cycle and all registers at reset values.
